// File: rtl/mask_pkg.sv
// Shared definitions for the mask-unit front-end arbiter: FSM state encoding
// and the default processing latency of the attached mask unit.
package mask_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam int MASK_LAT_DEF = 12;

endpackage

// File: rtl/mask_arbiter_if.sv
// Bundle of requester, response and mask-unit signals around mask_arbiter.
// slave = arbiter side, master = requesters / consumer / mask unit side.
interface mask_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int DATA_LEN = 8,
  parameter int MASK_LEN = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]               req_valid_i;
  logic [N_REQ-1:0]               req_ready_o;
  logic [N_REQ-1:0][DATA_LEN-1:0] req_data_i;
  logic [N_REQ-1:0][MASK_LEN-1:0] req_mask_i;
  logic                           rsp_valid_o;
  logic                           rsp_ready_i;
  logic [ID_W-1:0]                rsp_id_o;
  logic [DATA_LEN-1:0]            rsp_data_o;
  logic                           mask_pulse_o;
  logic [DATA_LEN-1:0]            mask_data_o;
  logic [MASK_LEN-1:0]            mask_mask_o;
  logic [DATA_LEN-1:0]            mask_signal_i;

  modport slave (
    input  req_valid_i, req_data_i, req_mask_i, rsp_ready_i, mask_signal_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o,
           mask_pulse_o, mask_data_o, mask_mask_o
  );

  modport master (
    output req_valid_i, req_data_i, req_mask_i, rsp_ready_i, mask_signal_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o,
           mask_pulse_o, mask_data_o, mask_mask_o
  );

endinterface

// File: rtl/mask_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// searching cyclically. Returns one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any_req
);

  int k;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!any_req && req[k]) begin
        any_req  = 1'b1;
        grant[k] = 1'b1;
        idx      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/mask_arbiter.sv
// Round-robin sequencer in front of a single shared mask unit: one job in
// flight, fixed-latency wait, result ANDed with the job mask and returned.
module mask_arbiter
  import mask_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_LEN = 8,
  parameter int MASK_LEN = 8,
  parameter int MASK_LAT = MASK_LAT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_N_i,
  mask_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MASK_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MASK_LAT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic                pulse_q, pulse_d;
  logic                rvld_q, rvld_d;
  logic [DATA_LEN-1:0] mdata_q, mdata_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [MASK_LEN-1:0] mmask_q, mmask_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     gidx;
  logic                any_req;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req     (bus.req_valid_i),
    .ptr     (ptr_q),
    .grant   (grant),
    .idx     (gidx),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rid_d   = rid_q;
    ready_d = '0;
    pulse_d = 1'b0;
    rvld_d  = rvld_q;
    mdata_d = mdata_q;
    rdata_d = rdata_q;
    mmask_d = mmask_q;
    case (state_q)
      S_INIT: begin
        // two cycles so the mask unit has left its own init state
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (any_req) begin
          ready_d = grant;
          mdata_d = bus.req_data_i[gidx];
          mmask_d = bus.req_mask_i[gidx];
          rid_d   = gidx;
          ptr_d   = (gidx == ID_LAST) ? '0 : gidx + 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        pulse_d = 1'b1;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          // unit leaves unmasked bits stale, so they must be cleared here
          rdata_d = bus.mask_signal_i & mmask_q;
          rvld_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          rvld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_N_i) begin
    if (!rst_N_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      rid_q   <= '0;
      ready_q <= '0;
      pulse_q <= 1'b0;
      rvld_q  <= 1'b0;
      mdata_q <= '0;
      rdata_q <= '0;
      mmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rid_q   <= rid_d;
      ready_q <= ready_d;
      pulse_q <= pulse_d;
      rvld_q  <= rvld_d;
      mdata_q <= mdata_d;
      rdata_q <= rdata_d;
      mmask_q <= mmask_d;
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.mask_pulse_o = pulse_q;
  assign bus.mask_data_o  = mdata_q;
  assign bus.mask_mask_o  = mmask_q;
  assign bus.rsp_valid_o  = rvld_q;
  assign bus.rsp_id_o     = rid_q;
  assign bus.rsp_data_o   = rdata_q;

endmodule

// File: tb/tb_mask_arbiter.sv
// Bench for mask_arbiter with a behavioural mask unit (keeps unmasked bits
// from earlier jobs) and an expected-response queue.
module tb_mask_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int MW    = 8;
  localparam int LAT   = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mask_arbiter_if #(.N_REQ(N_REQ), .DATA_LEN(DW), .MASK_LEN(MW)) bus ();

  mask_arbiter #(.N_REQ(N_REQ), .DATA_LEN(DW), .MASK_LEN(MW), .MASK_LAT(LAT)) dut (
    .clk_i   (clk),
    .rst_N_i (rst_n),
    .bus     (bus)
  );

  // mask unit model: 1 cycle to start, 9 processing cycles, masked bits update only
  logic [DW-1:0] u_sig, u_data;
  logic [MW-1:0] u_mask;
  logic          u_busy;
  int            u_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_sig <= '0; u_data <= '0; u_mask <= '0; u_busy <= 1'b0; u_cnt <= 0;
    end else if (bus.mask_pulse_o && !u_busy) begin
      u_busy <= 1'b1; u_cnt <= 0; u_data <= bus.mask_data_o; u_mask <= bus.mask_mask_o;
    end else if (u_busy) begin
      if (u_cnt == 9) begin
        u_sig  <= (u_sig & ~u_mask) | (u_data & u_mask);
        u_busy <= 1'b0;
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end
  assign bus.mask_signal_i = u_sig;

  typedef struct packed { logic [1:0] id; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  logic [N_REQ-1:0] gnt_log[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (|bus.req_ready_o) gnt_log.push_back(bus.req_ready_o);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic drive(input int k, input logic [DW-1:0] d, input logic [MW-1:0] m, input bit push);
    exp_t e;
    bus.req_valid_i[k] = 1'b1;
    bus.req_data_i[k]  = d;
    bus.req_mask_i[k]  = m;
    e.id   = 2'(k);
    e.data = d & m;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_ready(output logic [N_REQ-1:0] v, output bit ok);
    ok = 1'b0; v = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (|bus.req_ready_o) begin v = bus.req_ready_o; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  task automatic ack();
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== '0 || bus.mask_pulse_o !== 1'b0)
      begin n_bad++; $display("FAIL reset_ctrl: got vld=%b rdy=%b pls=%b want 0", bus.rsp_valid_o, bus.req_ready_o, bus.mask_pulse_o); end
    n_vec++;
    if ({bus.rsp_id_o, bus.rsp_data_o, bus.mask_data_o, bus.mask_mask_o} !== '0)
      begin n_bad++; $display("FAIL reset_data: got id=%h d=%h md=%h mm=%h want 0", bus.rsp_id_o, bus.rsp_data_o, bus.mask_data_o, bus.mask_mask_o); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== '0 || bus.mask_pulse_o !== 1'b0)
      begin n_bad++; $display("FAIL reset_held: got vld=%b rdy=%b pls=%b want 0", bus.rsp_valid_o, bus.req_ready_o, bus.mask_pulse_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    logic [N_REQ-1:0] v; bit ok; exp_t e; int t0, base;
    base = gnt_log.size();
    drive(0, 8'hA5, 8'h0F, 1'b1);
    t0 = cyc;
    wait_ready(v, ok);
    n_vec++; if (v !== 4'b0001) begin n_bad++; $display("FAIL basic_ready: got %b want 0001", v); end
    n_vec++; if (cyc !== t0 + 1) begin n_bad++; $display("FAIL basic_ready_time: got %0d want %0d", cyc - t0, 1); end
    tick(); bus.req_valid_i[0] = 1'b0;
    wait_rsp(ok); pop_exp(e);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL basic_rsp_timeout: got no rsp_valid want rsp"); end
    n_vec++; if (bus.rsp_id_o !== e.id || bus.rsp_data_o !== 8'h05)
      begin n_bad++; $display("FAIL basic_rsp: got id=%0d d=%h want id=%0d d=05", bus.rsp_id_o, bus.rsp_data_o, e.id); end
    n_vec++; if (cyc !== t0 + 15) begin n_bad++; $display("FAIL basic_latency: got %0d want 15", cyc - t0); end
    ack();
    repeat (3) tick();
    n_vec++; if (gnt_log.size() - base !== 1) begin n_bad++; $display("FAIL basic_grant_count: got %0d want 1", gnt_log.size() - base); end
  endtask

  task automatic test_stale();
    logic [N_REQ-1:0] v; bit ok; exp_t e;
    int            ks[2] = '{0, 1};
    logic [DW-1:0] ds[2] = '{8'hFF, 8'h00};
    logic [MW-1:0] ms[2] = '{8'hFF, 8'hF0};
    for (int j = 0; j < 2; j++) begin
      drive(ks[j], ds[j], ms[j], 1'b1);
      wait_ready(v, ok);
      n_vec++; if (v !== (4'b0001 << ks[j])) begin n_bad++; $display("FAIL stale_ready%0d: got %b want %b", j, v, 4'b0001 << ks[j]); end
      tick(); bus.req_valid_i[ks[j]] = 1'b0;
      wait_rsp(ok); pop_exp(e);
      n_vec++; if (!ok || bus.rsp_id_o !== e.id || bus.rsp_data_o !== e.data)
        begin n_bad++; $display("FAIL stale_rsp%0d: got ok=%b id=%0d d=%h want id=%0d d=%h", j, ok, bus.rsp_id_o, bus.rsp_data_o, e.id, e.data); end
      ack();
    end
  endtask

  task automatic test_rotation();
    logic [N_REQ-1:0] v; bit ok; exp_t e;
    logic [DW-1:0] ds[4] = '{8'hA5, 8'h3C, 8'hF0, 8'h81};
    logic [MW-1:0] ms[4] = '{8'hFF, 8'h0F, 8'h3C, 8'hC3};
    apply_reset();
    for (int k = 0; k < N_REQ; k++) drive(k, ds[k], ms[k], 1'b0);
    for (int i = 0; i < 5; i++) begin
      e.id = 2'(i % N_REQ); e.data = ds[i % N_REQ] & ms[i % N_REQ];
      sb.push_back(e);
      wait_ready(v, ok);
      n_vec++; if (v !== (4'b0001 << (i % N_REQ))) begin n_bad++; $display("FAIL rot_grant%0d: got %b want %b", i, v, 4'b0001 << (i % N_REQ)); end
      if (i == 4) begin tick(); bus.req_valid_i = '0; end
      wait_rsp(ok); pop_exp(e);
      n_vec++; if (!ok || bus.rsp_id_o !== e.id || bus.rsp_data_o !== e.data)
        begin n_bad++; $display("FAIL rot_rsp%0d: got ok=%b id=%0d d=%h want id=%0d d=%h", i, ok, bus.rsp_id_o, bus.rsp_data_o, e.id, e.data); end
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [N_REQ-1:0] v; bit ok, stable; exp_t e; int hs;
    drive(2, 8'h3C, 8'hFF, 1'b1);
    wait_ready(v, ok);
    n_vec++; if (v !== 4'b0100) begin n_bad++; $display("FAIL bp_ready: got %b want 0100", v); end
    tick(); bus.req_valid_i[2] = 1'b0;
    wait_rsp(ok); pop_exp(e);
    drive(3, 8'h96, 8'h3C, 1'b1);
    stable = ok;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== e.id || bus.rsp_data_o !== e.data || bus.req_ready_o !== '0)
        stable = 1'b0;
    end
    n_vec++; if (!stable) begin n_bad++; $display("FAIL bp_hold: got vld=%b id=%0d d=%h rdy=%b want 1 %0d %h 0000", bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_data_o, bus.req_ready_o, e.id, e.data); end
    hs = cyc;
    ack();
    wait_ready(v, ok);
    n_vec++; if (v !== 4'b1000 || cyc !== hs + 2) begin n_bad++; $display("FAIL bp_regrant: got %b at +%0d want 1000 at +2", v, cyc - hs); end
    tick(); bus.req_valid_i[3] = 1'b0;
    bus.rsp_ready_i = 1'b1;  // early ready must not produce a response
    wait_rsp(ok); pop_exp(e);
    n_vec++; if (!ok || bus.rsp_id_o !== e.id || bus.rsp_data_o !== e.data || cyc !== hs + 16)
      begin n_bad++; $display("FAIL bp_early_ready: got id=%0d d=%h at +%0d want id=%0d d=%h at +16", bus.rsp_id_o, bus.rsp_data_o, cyc - hs, e.id, e.data); end
    @(posedge clk); #1 bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_consumed: got vld=%b want 0", bus.rsp_valid_o); end
  endtask

  task automatic test_reset_midjob();
    logic [N_REQ-1:0] v; bit ok, quiet; exp_t e;
    tick();
    drive(1, 8'hA5, 8'hF0, 1'b0);
    wait_ready(v, ok);
    n_vec++; if (v !== 4'b0010) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0010", v); end
    tick(); bus.req_valid_i[1] = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.rsp_valid_o, bus.mask_pulse_o, bus.req_ready_o, bus.mask_data_o, bus.mask_mask_o, bus.rsp_data_o} !== '0)
      begin n_bad++; $display("FAIL rst_mid_outputs: got md=%h mm=%h vld=%b want all 0", bus.mask_data_o, bus.mask_mask_o, bus.rsp_valid_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.rsp_valid_o !== 1'b0) quiet = 1'b0; end
    n_vec++; if (!quiet) begin n_bad++; $display("FAIL rst_mid_dropped: got rsp_valid after reset want none"); end
    tick();
    drive(1, 8'h5A, 8'hFF, 1'b1);
    wait_ready(v, ok);
    n_vec++; if (v !== 4'b0010) begin n_bad++; $display("FAIL rst_mid_ready2: got %b want 0010", v); end
    tick(); bus.req_valid_i[1] = 1'b0;
    wait_rsp(ok); pop_exp(e);
    n_vec++; if (!ok || bus.rsp_id_o !== e.id || bus.rsp_data_o !== e.data)
      begin n_bad++; $display("FAIL rst_mid_rsp: got ok=%b id=%0d d=%h want id=%0d d=%h", ok, bus.rsp_id_o, bus.rsp_data_o, e.id, e.data); end
    ack();
  endtask

  task automatic test_drop();
    logic [N_REQ-1:0] v; bit ok, quiet; exp_t e; int base;
    base = gnt_log.size();
    drive(0, 8'hC3, 8'h0F, 1'b1);
    wait_ready(v, ok);
    n_vec++; if (v !== 4'b0001) begin n_bad++; $display("FAIL drop_ready: got %b want 0001", v); end
    tick(); bus.req_valid_i[0] = 1'b0;
    repeat (4) tick();
    bus.req_valid_i[2] = 1'b1; bus.req_data_i[2] = 8'hEE; bus.req_mask_i[2] = 8'hFF;
    tick(); bus.req_valid_i[2] = 1'b0;
    wait_rsp(ok); pop_exp(e);
    n_vec++; if (!ok || bus.rsp_id_o !== e.id || bus.rsp_data_o !== 8'h03)
      begin n_bad++; $display("FAIL drop_rsp: got ok=%b id=%0d d=%h want id=0 d=03", ok, bus.rsp_id_o, bus.rsp_data_o); end
    ack();
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== '0) quiet = 1'b0;
    end
    n_vec++; if (!quiet) begin n_bad++; $display("FAIL drop_quiet: got activity after drop want none"); end
    n_vec++; if (gnt_log.size() - base !== 1) begin n_bad++; $display("FAIL drop_grants: got %0d want 1", gnt_log.size() - base); end
    n_vec++; if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_empty: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_mask_i  = '0;
    bus.rsp_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_stale();
    test_rotation();
    test_backpressure();
    test_reset_midjob();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
